// File: rtl/struct_field_pkg.sv
// Shared types for the struct field-select sequencer.
// Imported by the sequencer top and anything bundling its results.
package struct_field_pkg;

  localparam int FIELD_WIDTH = 4;
  localparam int NUM_STEPS   = 4;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  typedef logic [1:0] step_t;

  typedef struct packed {
    logic [FIELD_WIDTH-1:0] x;
    logic [FIELD_WIDTH-1:0] y;
  } field_pair_t;

endpackage

// File: rtl/struct_field_sequencer.sv
// Sweeps the four (p1,p2) selector combos over one word and
// returns the captured {x,y} pairs as one packed result.
module struct_field_sequencer
  import struct_field_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      dp_data,
  output logic                   dp_p1,
  output logic                   dp_p2,
  input  logic [FIELD_W-1:0]     dp_x,
  input  logic [FIELD_W-1:0]     dp_y,
  output logic                   out_valid,
  output logic [8*FIELD_W-1:0]   out_result,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       words_done
);

  localparam int PAIR_W = 2 * FIELD_W;
  localparam step_t LAST = step_t'(NUM_STEPS - 1);

  state_t state_q, state_d;
  step_t  step_q, step_d;

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_STEPS-1:0][PAIR_W-1:0] res_q, res_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    dp_p1     = 1'b0;
    dp_p2     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          step_d  = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        busy          = 1'b1;
        dp_p1         = step_q[1];
        dp_p2         = step_q[0];
        res_d[step_q] = {dp_x, dp_y};
        step_d        = step_t'(step_q + 2'd1);
        if (step_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // new word may ride on the same cycle the result leaves
        in_ready  = out_ready;
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (in_valid) begin
            word_d  = in_data;
            step_d  = '0;
            state_d = STEP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp_data    = word_q;
  assign out_result = res_q;
  assign words_done = cnt_q;

endmodule

// File: tb/tb_struct_field_sequencer.sv
// Scoreboarded bench for struct_field_sequencer with a
// behavioural datapath and a wrap-width twin instance.
module tb_struct_field_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready, dp_p1, dp_p2, out_valid, busy;
  logic [31:0] dp_data, out_result;
  logic [3:0]  dp_x, dp_y;
  logic [15:0] words_done;

  logic        w_in_ready, w_p1, w_p2, w_ov, w_busy;
  logic [31:0] w_data, w_res;
  logic [3:0]  w_x, w_y;
  logic [1:0]  w_done;

  int errors = 0;
  int checks = 0;
  int cnt_model = 0;
  bit mon_en = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // datapath: x = low nibble, y = high nibble of byte {p1,p2}
  function automatic logic [3:0] dpf(logic [31:0] d, logic p1,
                                      logic p2, bit hi);
    int s;
    s = 8 * int'({p1, p2}) + (hi ? 4 : 0);
    return d[s +: 4];
  endfunction

  assign dp_x = dpf(dp_data, dp_p1, dp_p2, 1'b0);
  assign dp_y = dpf(dp_data, dp_p1, dp_p2, 1'b1);
  assign w_x  = dpf(w_data, w_p1, w_p2, 1'b0);
  assign w_y  = dpf(w_data, w_p1, w_p2, 1'b1);

  // reference: slot k holds {lo nibble, hi nibble} of byte k
  function automatic logic [31:0] exp_res(logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      r[8*k +: 8] = {b[3:0], b[7:4]};
    end
    return r;
  endfunction

  struct_field_sequencer u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_data(dp_data), .dp_p1(dp_p1), .dp_p2(dp_p2),
    .dp_x(dp_x), .dp_y(dp_y),
    .out_valid(out_valid), .out_result(out_result),
    .out_ready(out_ready), .busy(busy), .words_done(words_done)
  );

  struct_field_sequencer #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .dp_data(w_data), .dp_p1(w_p1), .dp_p2(w_p2),
    .dp_x(w_x), .dp_y(w_y),
    .out_valid(w_ov), .out_result(w_res),
    .out_ready(out_ready), .busy(w_busy), .words_done(w_done)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  logic        prev_ov = 0, prev_hs = 0, prev_rst = 1;
  logic [31:0] prev_res = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("words_done", 64'(words_done), 64'(16'(cnt_model)));
      chk("wrap_words_done", 64'(w_done), 64'(cnt_model % 4));
      if (prev_ov && !prev_hs && !prev_rst) begin
        chk("ov_hold", 64'(out_valid), 64'd1);
        chk("res_hold", 64'(out_result), 64'(prev_res));
      end
      if (rst) begin
        cnt_model = 0;
        exp_q.delete();
      end else begin
        if (in_valid && in_ready)
          exp_q.push_back(exp_res(in_data));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(out_result), 64'hdead);
          end else begin
            chk("result", 64'(out_result), 64'(exp_q.pop_front()));
          end
          cnt_model++;
        end
      end
      prev_ov  = out_valid;
      prev_hs  = out_valid && out_ready;
      prev_rst = rst;
      prev_res = out_result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, output longint t);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    t = longint'($time / 10);
    #1;
  endtask

  task automatic wait_ov();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("ov_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid) break;
      tick();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
  endtask

  logic [31:0] stream [4] = '{32'h8f8259e4, 32'h80ad046a,
                              32'hbf93017e, 32'he6458a2d};

  initial begin
    longint t, tprev;
    logic [31:0] snap;
    int base;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    mon_en = 1;
    tick();
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sel", 64'({dp_p1, dp_p2}), 64'd0);
    chk("rst_dp_data", 64'(dp_data), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_words", 64'(words_done), 64'd0);

    // reset on third STEP cycle
    send(32'h12345678, t);
    in_valid = 1'b0;
    tick();
    tick();
    chk("third_step_sel", 64'({dp_p1, dp_p2}), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sel", 64'({dp_p1, dp_p2}), 64'd0);
    chk("abort_dp_data", 64'(dp_data), 64'd0);
    chk("abort_result", 64'(out_result), 64'd0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_ov", 64'(out_valid), 64'd0);
      tick();
    end
    chk("abort_words", 64'(words_done), 64'd0);

    // idle stability
    for (int i = 0; i < 20; i++) begin
      chk("idle_sel", 64'({dp_p1, dp_p2}), 64'd0);
      chk("idle_ov", 64'(out_valid), 64'd0);
      tick();
    end

    // single word
    send(32'ha7107338, t);
    in_valid = 1'b0;
    chk("single_in_ready_low", 64'(in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("single_sel", 64'({dp_p1, dp_p2}), 64'(k));
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_ov_low", 64'(out_valid), 64'd0);
      tick();
    end
    chk("single_ov_n5", 64'(out_valid), 64'd1);
    chk("single_res", 64'(out_result), 64'(exp_res(32'ha7107338)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_words", 64'(words_done), 64'd1);
    chk("single_ov_clear", 64'(out_valid), 64'd0);

    // back-to-back stream
    base = int'(words_done);
    out_ready = 1'b1;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      send(stream[i], t);
      if (i > 0) chk("b2b_spacing", 64'(t - tprev), 64'd5);
      tprev = t;
    end
    drain();
    chk("b2b_words", 64'(int'(words_done) - base), 64'd4);
    chk("wrap_after_5", 64'(w_done), 64'd1);
    chk("total_after_5", 64'(words_done), 64'd5);

    // backpressure
    send(32'h5a5a0ff0, t);
    in_valid = 1'b0;
    wait_ov();
    in_valid = 1'b1;
    in_data  = 32'h0badf00d;
    snap = out_result;
    for (int i = 0; i < 7; i++) begin
      chk("bp_res_stable", 64'(out_result), 64'(snap));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_ov", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_same_cycle_accept", 64'(busy), 64'd1);
    chk("bp_restart_sel", 64'({dp_p1, dp_p2}), 64'd0);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/struct_field_sequencer.md
# struct_field_sequencer

Controller that feeds 32-bit words, one at a time, into the struct field-select datapath (`Example`: `data`, `p1`, `p2` in; 4-bit `out_x`, `out_y` out). For each word it sweeps all four selector combinations, one per cycle, and captures both field outputs on every step. It then returns one packed 32-bit result through a valid/ready handshake. It sits between a word source and a result sink, replacing the bench-style exhaustive selector stimulus with a synthesizable sequencer.

## Interface
- `DATA_W`, 32: word width; must equal the datapath `data` width.
- `FIELD_W`, 4: width of each of `out_x` and `out_y`.
- `CNT_W`, 16: width of the completed-word counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  a source word is offered.
- `in_data`  in  DATA_W  the source word.
- `in_ready`  out  1  the sequencer accepts a word this cycle.
- `dp_data`  out  DATA_W  word driven to the datapath `data` input.
- `dp_p1`  out  1  datapath `p1` selector.
- `dp_p2`  out  1  datapath `p2` selector.
- `dp_x`  in  FIELD_W  datapath `out_x`; combinational from the `dp_*` outputs.
- `dp_y`  in  FIELD_W  datapath `out_y`; combinational from the `dp_*` outputs.
- `out_valid`  out  1  a packed result is available.
- `out_result`  out  8*FIELD_W  packed result: {x3,y3,x2,y2,x1,y1,x0,y0}, where k is the step index.
- `out_ready`  in  1  the sink takes the result.
- `busy`  out  1  high in state STEP.
- `words_done`  out  CNT_W  count of completed output handshakes.

## Operation
- The FSM has three states: IDLE, STEP, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch `in_data` into `word_q`, clear `step` to 0, go to STEP.
- STEP:
  - Drive `dp_data` = `word_q`, `dp_p1` = `step[1]`, `dp_p2` = `step[0]`.
  - Each cycle, capture {`dp_x`,`dp_y`} into result slot `step`, then increment `step`.
  - After the step-3 capture, go to DONE.
  - `in_ready` = 0.
- DONE:
  - `out_valid` = 1. `out_result` and `word_q` are held stable until the handshake.
  - On `out_ready`, increment `words_done`.
  - If `in_valid` is also high that cycle, accept the new word (`in_ready` = `out_ready`), restart at step 0 and go to STEP. Otherwise go to IDLE.
- Outside STEP, `dp_p1` = `dp_p2` = 0 and `dp_data` = `word_q`.
- `words_done` wraps modulo 2^CNT_W without saturating.
- `in_ready` is a function of state and `out_ready` only. It never depends on `in_valid`.
- `out_valid`, once asserted, stays high until `out_ready`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `dp_p1`/`dp_p2` 0, `dp_data` 0, `out_result` 0, `words_done` 0, `step` 0.
- Latency: accept at edge N. STEP occupies cycles N+1..N+4, with selectors (p1,p2) = 00, 01, 10, 11. `out_valid` is high from cycle N+5.
- Throughput: with `out_ready` held at 1 and `in_valid` held at 1, one word completes every 5 cycles.
- `rst` asserted mid-STEP or in DONE aborts the operation. The pending result is discarded and the counter is not incremented.
- In IDLE, `in_valid` = 0 leaves every output unchanged.
- In DONE, `out_ready` = 0 with `in_valid` = 1: the result is held and the input is not accepted.

## Structure
- A shared package `struct_field_pkg` holds:
  - a `state_t` enum {IDLE, STEP, DONE};
  - a `step_t` type (2 bits);
  - a packed `field_pair_t` {x, y}, FIELD_W each;
  - a `NUM_STEPS` = 4 constant.
- No sub-module. The datapath is instantiated beside the sequencer, not inside it.

## Test plan
- Single word: after reset, present `in_data` = 32'ha7107338.
  - `in_ready` falls one cycle after acceptance.
  - (`dp_p1`,`dp_p2`) steps 00, 01, 10, 11 over 4 cycles.
  - `out_valid` rises at acceptance +5.
  - `out_result` equals the datapath outputs captured per step.
  - `words_done` = 1 after the handshake.
- Back-to-back stream: present 32'h8f8259e4, 32'h80ad046a, 32'hbf93017e, 32'he6458a2d with `in_valid` and `out_ready` held at 1.
  - Results appear in order at 5-cycle spacing.
  - `words_done` = 4.
- Backpressure: hold `out_ready` = 0 for 7 cycles in DONE.
  - `out_result` is stable throughout.
  - `in_ready` = 0 throughout.
  - The next word is accepted in the same cycle that `out_ready` rises.
- Reset mid-operation: assert `rst` on the third STEP cycle.
  - The next cycle shows IDLE reset values.
  - `out_valid` never rises.
  - `words_done` is unchanged at 0.
- Counter wrap: build with CNT_W = 2 and complete 5 words; `words_done` reads 1.
- Idle stability: `in_valid` = 0 for 20 cycles.
  - `dp_p1`/`dp_p2` stay 0.
  - `out_valid` stays 0.
